// File: rtl/wb_trace_oled_pkg.sv
// Shared types and constants for the writeback trace renderer:
// trace entry layout, FSM states and ASCII helpers.
package wb_trace_oled_pkg;

   localparam logic [5:0] OP_HALT  = 6'b111111;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_R  = 8'h52;
   localparam logic [7:0] ASCII_EQ = 8'h3D;
   localparam logic [7:0] ASCII_H  = 8'h48;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_L  = 8'h4C;
   localparam logic [7:0] ASCII_T  = 8'h54;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EMIT,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  wreg;
      logic [31:0] result;
   } trace_entry_t;

   // Upper-case hex digit.
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'b0000, nib};
      else             return 8'h37 + {4'b0000, nib};
   endfunction

endpackage

// File: rtl/wb_trace_oled_fifo.sv
// Synchronous FIFO of trace entries; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module trace_fifo
   import wb_trace_oled_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  trace_entry_t din_i,
   output trace_entry_t dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   trace_entry_t   mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           wr_en, rd_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/wb_trace_oled.sv
// Captures writeback register writes and the halt marker, queues them and
// renders each as a 16-character text line onto the OLED character buffer.
//
//   state   | meaning
//   IDLE    | waiting for a queued event
//   LOAD    | pop FIFO head into the line register
//   EMIT    | drive cols 0..15 of the current row, one per disp_ready
//   DONE    | halt line shown; capture and display frozen until reset
module wb_trace_oled
   import wb_trace_oled_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ROWS  = 4
) (
   input  logic        sysclk,
   input  logic        cpu_resetn,
   input  logic [4:0]  wreg_w,
   input  logic [31:0] result_w,
   input  logic [5:0]  op_w,
   input  logic        disp_ready,
   output logic        disp_we,
   output logic [5:0]  disp_addr,
   output logic [7:0]  disp_data,
   output logic        ovf,
   output logic [7:0]  drop_cnt,
   output logic        halted
);

   state_e       state_q, state_d;
   logic [3:0]   col_q, col_d;
   logic [1:0]   row_q, row_d;
   trace_entry_t line_q, line_d;
   logic         halt_seen_q, halt_seen_d;
   logic         ovf_q, ovf_d;
   logic [7:0]   drop_q, drop_d;

   trace_entry_t push_entry, head_entry;
   logic         capture, pop, fifo_full, fifo_empty, drop_evt;
   logic         line_is_halt;
   logic [3:0]   nib_sel, res_nib;
   logic [7:0]   char_sel;

   assign capture    = ((wreg_w != 5'd0) || (op_w == OP_HALT)) &&
                       !halt_seen_q && (state_q != ST_DONE);
   assign push_entry = '{op: op_w, wreg: wreg_w, result: result_w};
   assign pop        = (state_q == ST_LOAD);
   assign drop_evt   = capture && fifo_full && !pop;

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (sysclk),
      .rst_n_i (cpu_resetn),
      .push_i  (capture),
      .pop_i   (pop),
      .din_i   (push_entry),
      .dout_o  (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      halt_seen_d = halt_seen_q;
      ovf_d       = ovf_q;
      drop_d      = drop_q;
      if (drop_evt) begin
         ovf_d = 1'b1;
         if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else if (capture && (op_w == OP_HALT)) begin
         halt_seen_d = 1'b1;
      end
   end

   assign line_is_halt = (line_q.op == OP_HALT);

   // Result nibbles occupy cols 4..11, most significant first.
   always_comb begin
      nib_sel  = 4'd11 - col_q;
      res_nib  = 4'(line_q.result >> {nib_sel[2:0], 2'b00});
      char_sel = ASCII_SP;
      if (line_is_halt) begin
         case (col_q)
            4'd0:    char_sel = ASCII_H;
            4'd1:    char_sel = ASCII_A;
            4'd2:    char_sel = ASCII_L;
            4'd3:    char_sel = ASCII_T;
            default: char_sel = ASCII_SP;
         endcase
      end else begin
         case (col_q)
            4'd0:    char_sel = ASCII_R;
            4'd1:    char_sel = hex_to_ascii({3'b000, line_q.wreg[4]});
            4'd2:    char_sel = hex_to_ascii(line_q.wreg[3:0]);
            4'd3:    char_sel = ASCII_EQ;
            default: if (col_q <= 4'd11) char_sel = hex_to_ascii(res_nib);
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      line_d  = line_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
         ST_LOAD: begin
            line_d  = head_entry;
            col_d   = 4'd0;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (disp_ready) begin
               if (col_q == 4'd15) begin
                  col_d = 4'd0;
                  row_d = (row_q == 2'(ROWS-1)) ? 2'd0 : row_q + 2'd1;
                  // Skip IDLE when more is queued to keep one event per 17 cycles.
                  if (line_is_halt)     state_d = ST_DONE;
                  else if (!fifo_empty) state_d = ST_LOAD;
                  else                  state_d = ST_IDLE;
               end else begin
                  col_d = col_q + 4'd1;
               end
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q     <= ST_IDLE;
         col_q       <= 4'd0;
         row_q       <= 2'd0;
         line_q      <= '0;
         halt_seen_q <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         line_q      <= line_d;
         halt_seen_q <= halt_seen_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
      end
   end

   assign disp_we   = (state_q == ST_EMIT);
   assign disp_addr = {row_q, col_q};
   assign disp_data = (state_q == ST_EMIT) ? char_sel : ASCII_SP;
   assign ovf       = ovf_q;
   assign drop_cnt  = drop_q;
   assign halted    = (state_q == ST_DONE);

endmodule

// File: tb/tb_wb_trace_oled.sv
// Directed bench for wb_trace_oled: collects rendered lines from the
// display port and compares them with hand-computed text.
module tb_wb_trace_oled;

   logic        sysclk = 1'b0;
   logic        cpu_resetn;
   logic [4:0]  wreg_w;
   logic [31:0] result_w;
   logic [5:0]  op_w;
   logic        disp_ready;
   logic        disp_we;
   logic [5:0]  disp_addr;
   logic [7:0]  disp_data;
   logic        ovf;
   logic [7:0]  drop_cnt;
   logic        halted;

   wb_trace_oled #(.DEPTH(8), .ROWS(4)) dut (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .wreg_w     (wreg_w),
      .result_w   (result_w),
      .op_w       (op_w),
      .disp_ready (disp_ready),
      .disp_we    (disp_we),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .ovf        (ovf),
      .drop_cnt   (drop_cnt),
      .halted     (halted)
   );

   always #5 sysclk = ~sysclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] line_str(input logic [4:0] w, input logic [31:0] v);
      string        hx;
      logic [127:0] s;
      hx = "0123456789ABCDEF";
      s[127:120] = "R";
      s[119:112] = hx[int'(w[4])];
      s[111:104] = hx[int'(w[3:0])];
      s[103:96]  = "=";
      for (int k = 0; k < 8; k++) s[95-8*k -: 8] = hx[int'(v[31-4*k -: 4])];
      s[31:0] = "    ";
      return s;
   endfunction

   // Display-side collector: characters accepted on the next edge.
   logic [127:0] lines_q[$];
   logic [1:0]   rows_q[$];
   logic [127:0] cur_line;
   int           cyc = 0;
   int           we_cycles = 0;
   int           first_we_cyc = -1;
   bit           stab_en = 1'b0;
   logic         prev_we = 1'b0, prev_rdy = 1'b0;
   logic [5:0]   prev_addr;
   logic [7:0]   prev_data;

   always @(posedge sysclk) cyc++;

   always @(negedge sysclk) begin
      int c;
      if (disp_we) begin
         we_cycles++;
         if (first_we_cyc < 0) first_we_cyc = cyc;
      end
      if (stab_en && prev_we && !prev_rdy) begin
         check_val("hold_addr", 128'(disp_addr), 128'(prev_addr));
         check_val("hold_data", 128'(disp_data), 128'(prev_data));
      end
      if (disp_we && disp_ready) begin
         c = int'(disp_addr[3:0]);
         cur_line[8*(15-c) +: 8] = disp_data;
         if (c == 15) begin
            lines_q.push_back(cur_line);
            rows_q.push_back(disp_addr[5:4]);
         end
      end
      prev_we   = disp_we;
      prev_rdy  = disp_ready;
      prev_addr = disp_addr;
      prev_data = disp_data;
   end

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic fire(input logic [4:0] w, input logic [31:0] r, input logic [5:0] op);
      wreg_w   = w;
      result_w = r;
      op_w     = op;
      step();
      wreg_w   = 5'd0;
      op_w     = 6'd0;
   endtask

   task automatic wait_lines(input int n, input int max_cyc, input string tag);
      int k;
      k = 0;
      while (lines_q.size() < n && k < max_cyc) begin
         step();
         k++;
      end
      check_val(tag, 128'(lines_q.size()), 128'(n));
   endtask

   task automatic do_reset();
      cpu_resetn = 1'b0;
      step();
      step();
      cpu_resetn = 1'b1;
      step();
      lines_q.delete();
      rows_q.delete();
   endtask

   localparam logic [127:0] HALT_LINE = {"HALT", 96'h202020202020202020202020};

   initial begin
      int c0;
      int exp3 [10];
      bit found;
      cpu_resetn = 1'b0;
      wreg_w     = 5'd0;
      result_w   = 32'd0;
      op_w       = 6'd0;
      disp_ready = 1'b1;
      #12;
      check_val("rst_we",     128'(disp_we),   128'(0));
      check_val("rst_addr",   128'(disp_addr), 128'(0));
      check_val("rst_data",   128'(disp_data), 128'(8'h20));
      check_val("rst_ovf",    128'(ovf),       128'(0));
      check_val("rst_drop",   128'(drop_cnt),  128'(0));
      check_val("rst_halted", 128'(halted),    128'(0));
      do_reset();

      // 1: single write, latency and strobe length
      we_cycles    = 0;
      first_we_cyc = -1;
      c0 = cyc;
      fire(5'd9, 32'd55, 6'd0);
      wait_lines(1, 60, "t1_lines");
      step();
      check_val("t1_text",    lines_q[0], "R09=00000037    ");
      check_val("t1_row",     128'(rows_q[0]), 128'(0));
      check_val("t1_wecnt",   128'(we_cycles), 128'(16));
      check_val("t1_latency", 128'(first_we_cyc - c0), 128'(3));

      // 2: five writes then halt, later writes ignored
      do_reset();
      for (int i = 1; i <= 5; i++) fire(5'(i), 32'h100 + 32'(i), 6'd0);
      fire(5'd0, 32'd0, 6'h3F);
      wait_lines(6, 200, "t2_lines");
      step();
      step();
      for (int i = 1; i <= 5; i++) begin
         check_val($sformatf("t2_text%0d", i), lines_q[i-1], line_str(5'(i), 32'h100 + 32'(i)));
         check_val($sformatf("t2_row%0d", i), 128'(rows_q[i-1]), 128'((i-1) % 4));
      end
      check_val("t2_halt_text", lines_q[5], HALT_LINE);
      check_val("t2_halt_row",  128'(rows_q[5]), 128'(1));
      check_val("t2_halted",    128'(halted), 128'(1));
      check_val("t2_we_off",    128'(disp_we), 128'(0));
      for (int i = 0; i < 3; i++) fire(5'd3, 32'hAAAA, 6'd0);
      repeat (40) step();
      check_val("t2_ignored", 128'(lines_q.size()), 128'(6));
      check_val("t2_drop",    128'(drop_cnt), 128'(0));
      check_val("t2_ovf",     128'(ovf), 128'(0));

      // 3: write every cycle for 30 cycles
      do_reset();
      for (int i = 0; i < 30; i++) fire(5'd5, 32'(i), 6'd0);
      exp3 = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 19};
      wait_lines(10, 400, "t3_lines");
      repeat (40) step();
      check_val("t3_no_extra", 128'(lines_q.size()), 128'(10));
      for (int i = 0; i < 10; i++)
         check_val($sformatf("t3_text%0d", i), lines_q[i], line_str(5'd5, 32'(exp3[i])));
      check_val("t3_ovf",  128'(ovf), 128'(1));
      check_val("t3_drop", 128'(drop_cnt), 128'(20));

      // 4: stalled display, continues at row 2 after ten lines
      lines_q.delete();
      rows_q.delete();
      stab_en = 1'b1;
      fire(5'd31, 32'hDEADBEEF, 6'd0);
      for (int k = 0; k < 200 && lines_q.size() < 1; k++) begin
         disp_ready = (k % 3 == 0);
         step();
      end
      stab_en    = 1'b0;
      disp_ready = 1'b1;
      check_val("t4_lines", 128'(lines_q.size()), 128'(1));
      check_val("t4_text",  lines_q[0], "R1F=DEADBEEF    ");
      check_val("t4_row",   128'(rows_q[0]), 128'(2));

      // 5: reset in the middle of a line
      do_reset();
      fire(5'd1, 32'h11, 6'd0);
      fire(5'd2, 32'h22, 6'd0);
      fire(5'd3, 32'h33, 6'd0);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge sysclk);
         if (disp_we && disp_addr[3:0] == 4'd7) found = 1'b1;
      end
      check_val("t5_reach_col7", 128'(found), 128'(1));
      #2;
      cpu_resetn = 1'b0;
      #1;
      check_val("t5_we",     128'(disp_we),   128'(0));
      check_val("t5_addr",   128'(disp_addr), 128'(0));
      check_val("t5_data",   128'(disp_data), 128'(8'h20));
      check_val("t5_ovf",    128'(ovf),       128'(0));
      check_val("t5_drop",   128'(drop_cnt),  128'(0));
      check_val("t5_halted", 128'(halted),    128'(0));
      step();
      cpu_resetn = 1'b1;
      lines_q.delete();
      rows_q.delete();
      we_cycles = 0;
      repeat (25) step();
      check_val("t5_fifo_empty", 128'(we_cycles), 128'(0));
      fire(5'd7, 32'h1234ABCD, 6'd0);
      wait_lines(1, 60, "t5_lines");
      check_val("t5_text", lines_q[0], line_str(5'd7, 32'h1234ABCD));
      check_val("t5_row",  128'(rows_q[0]), 128'(0));

      // 6: drop counter saturation with the display stalled
      do_reset();
      disp_ready = 1'b0;
      for (int k = 0; k < 269; k++) fire(5'd6, (k < 9) ? 32'(k) : 32'(1000 + k), 6'd0);
      step();
      check_val("t6_drop_sat", 128'(drop_cnt), 128'(8'hFF));
      check_val("t6_ovf",      128'(ovf), 128'(1));
      disp_ready = 1'b1;
      wait_lines(9, 300, "t6_lines");
      repeat (30) step();
      check_val("t6_no_extra", 128'(lines_q.size()), 128'(9));
      for (int i = 0; i < 9; i++)
         check_val($sformatf("t6_text%0d", i), lines_q[i], line_str(5'd6, 32'(i)));
      check_val("t6_drop_hold", 128'(drop_cnt), 128'(8'hFF));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
